// File: rtl/prm_edge_query_seq.sv
// rtl/prm_edge_query_seq.sv - PRM obstacle-check initiator: scans a run of edge codes through the checker.
// Optional early exit on first blocked code: define PRM_EDGE_EARLY_EXIT_EN.
module prm_edge_query_seq #(
  parameter int VEC_W   = 15,
  parameter int MAX_N   = 32,
  parameter int CNT_W   = 6,
  parameter int CHK_LAT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VEC_W-1:0] req_base,
  input  logic [CNT_W-1:0] req_len,
  output logic [VEC_W-1:0] chk_vec,
  input  logic             chk_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [MAX_N-1:0] rsp_bitmap,
  output logic             rsp_blocked,
  output logic [CNT_W-1:0] rsp_first,
  output logic [CNT_W-1:0] rsp_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;

  localparam logic [2:0]       LAT   = 3'(CHK_LAT);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_N);

  state_t           state, state_nx;
  logic [CNT_W-1:0] len_q, idx, len_c;
  logic [2:0]       dly;
  logic             hit, accept, sample, last, stop;

  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == DONE);
  assign rsp_blocked = hit;
  assign accept      = req_valid && req_ready;
  assign len_c       = (req_len > MAX_L) ? MAX_L : req_len;
  assign sample      = ((state == DRIVE) || (state == WAIT)) && (dly == LAT);
  assign last        = (idx == len_q - CNT_W'(1));
`ifdef PRM_EDGE_EARLY_EXIT_EN
  assign stop        = last || chk_mask;
`else
  assign stop        = last;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // WAIT only appears when CHK_LAT > 0: it covers the hold cycles of each code.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (accept) state_nx = (len_c == '0) ? DONE : DRIVE;
      DRIVE, WAIT: if (sample) state_nx = stop ? DONE : DRIVE;
                   else        state_nx = WAIT;
      DONE:        if (rsp_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      chk_vec    <= '0;
      len_q      <= '0;
      idx        <= '0;
      dly        <= '0;
      hit        <= 1'b0;
      rsp_bitmap <= '0;
      rsp_first  <= '0;
      rsp_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_bitmap <= '0;
            rsp_first  <= '0;
            rsp_count  <= '0;
            hit        <= 1'b0;
            idx        <= '0;
            dly        <= '0;
            len_q      <= len_c;
            if (len_c != '0) chk_vec <= req_base;
          end
        end
        DRIVE, WAIT: begin
          if (sample) begin
            rsp_bitmap <= rsp_bitmap | (MAX_N'(chk_mask) << idx);
            if (chk_mask && !hit) rsp_first <= idx;
            if (chk_mask) hit <= 1'b1;
            rsp_count <= rsp_count + CNT_W'(chk_mask);
            if (!stop) begin
              idx     <= idx + CNT_W'(1);
              chk_vec <= chk_vec + VEC_W'(1);
              dly     <= '0;
            end
          end else begin
            dly <= dly + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb/tb_prm_edge_query_seq.sv - self-checking bench for prm_edge_query_seq (CHK_LAT=0 and CHK_LAT=2 instances).
module tb_prm_edge_query_seq;

  typedef struct {
    logic [14:0] base;
    int          len;
    logic [31:0] pat;
    int          hold;
    logic [31:0] exp_bm;
  } vec_t;

  typedef struct {
    logic [31:0] bm;
    logic        blk;
    logic [5:0]  first;
    logic [5:0]  cnt;
    int          lat;
    int          scanned;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic        req_valid0 = 1'b0, req_ready0, chk_mask0, rsp_valid0, rsp_ready0 = 1'b0, rsp_blocked0;
  logic [14:0] req_base0 = '0, chk_vec0;
  logic [5:0]  req_len0 = '0, rsp_first0, rsp_count0;
  logic [31:0] rsp_bitmap0;

  logic        req_valid2 = 1'b0, req_ready2, chk_mask2 = 1'b0, rsp_valid2, rsp_ready2 = 1'b0, rsp_blocked2;
  logic [14:0] req_base2 = '0, chk_vec2;
  logic [5:0]  req_len2 = '0, rsp_first2, rsp_count2;
  logic [31:0] rsp_bitmap2;

  logic [14:0] mbase0 = '0, off0;
  logic [31:0] mpat0 = '0;

  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  // Checker model for the CHK_LAT=0 instance: blocked codes are a bit pattern relative to the query base.
  always_comb begin
    off0      = chk_vec0 - mbase0;
    chk_mask0 = (off0 < 15'd32) ? mpat0[off0[4:0]] : 1'b0;
  end

  prm_edge_query_seq #(.VEC_W(15), .MAX_N(32), .CNT_W(6), .CHK_LAT(0)) dut0 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid0), .req_ready(req_ready0), .req_base(req_base0),
    .req_len(req_len0), .chk_vec(chk_vec0), .chk_mask(chk_mask0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_bitmap(rsp_bitmap0), .rsp_blocked(rsp_blocked0),
    .rsp_first(rsp_first0), .rsp_count(rsp_count0));

  prm_edge_query_seq #(.VEC_W(15), .MAX_N(32), .CNT_W(6), .CHK_LAT(2)) dut2 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid2), .req_ready(req_ready2), .req_base(req_base2),
    .req_len(req_len2), .chk_vec(chk_vec2), .chk_mask(chk_mask2), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready2), .rsp_bitmap(rsp_bitmap2), .rsp_blocked(rsp_blocked2),
    .rsp_first(rsp_first2), .rsp_count(rsp_count2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic exp_t model(input logic [31:0] pat, input int len, input int lat);
    exp_t e;
    int   eff;
    bit   stop;
    e    = '{default: 0};
    eff  = (len > 32) ? 32 : len;
    stop = 1'b0;
    for (int i = 0; i < eff && !stop; i++) begin
      e.scanned = i + 1;
      if (pat[i]) begin
        e.bm[i] = 1'b1;
        e.blk   = 1'b1;
        if (e.cnt == 6'd0) e.first = 6'(i);
        e.cnt = e.cnt + 6'd1;
`ifdef PRM_EDGE_EARLY_EXIT_EN
        stop = 1'b1;
`endif
      end
    end
    e.lat = (eff == 0) ? 1 : e.scanned * (lat + 1) + 1;
    return e;
  endfunction

  task automatic cmp_rsp(input string tag, input logic [31:0] bm, input logic blk,
                         input logic [5:0] first, input logic [5:0] cnt);
    exp_t e;
    if (sb.size() == 0) begin
      bound_fail({tag, "_sb_empty"});
      return;
    end
    e = sb.pop_front();
    check({tag, "_bitmap"},  bm, e.bm);
    check({tag, "_blocked"}, 32'(blk), 32'(e.blk));
    check({tag, "_first"},   32'(first), 32'(e.first));
    check({tag, "_count"},   32'(cnt), 32'(e.cnt));
  endtask

  task automatic run0(input vec_t v);
    exp_t        e;
    int          k;
    bit          got;
    logic [14:0] ev;
    e         = model(v.pat, v.len, 0);
    mbase0    = v.base;
    mpat0     = v.pat;
    req_base0 = v.base;
    req_len0  = 6'(v.len);
    req_valid0 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      got = req_ready0;
      @(posedge CLK); #1;
    end
    req_valid0 = 1'b0;
    if (!got) begin
      bound_fail("accept0");
      return;
    end
    sb.push_back(e);
    k = 0;
    while (!rsp_valid0 && k < 2000) begin
      ev = v.base + 15'(k);
      check("chk_vec0", 32'(chk_vec0), 32'(ev));
      @(posedge CLK); #1;
      k++;
    end
    check("latency0", 32'(k + 1), 32'(e.lat));
    check("bitmap_tbl", rsp_bitmap0, v.exp_bm);
    for (int h = 0; h < v.hold; h++) begin
      check("stall_bitmap", rsp_bitmap0, e.bm);
      check("stall_count", 32'(rsp_count0), 32'(e.cnt));
      check("stall_valid", 32'(rsp_valid0), 32'd1);
      check("stall_req_ready", 32'(req_ready0), 32'd0);
      @(posedge CLK); #1;
    end
    rsp_ready0 = 1'b1;
    cmp_rsp("rsp0", rsp_bitmap0, rsp_blocked0, rsp_first0, rsp_count0);
    @(posedge CLK); #1;
    rsp_ready0 = 1'b0;
    check("post_valid0", 32'(rsp_valid0), 32'd0);
    check("post_ready0", 32'(req_ready0), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          c;
    int          ix;
    bit          got;
    bit          seen;
    exp_t        e;
    logic [31:0] p2;
    logic [14:0] ev;

`ifdef PRM_EDGE_EARLY_EXIT_EN
    tbl[0] = '{15'h0100, 4,  32'h0000_0000, 0, 32'h0000_0000};
    tbl[1] = '{15'h0010, 8,  32'h0000_0044, 0, 32'h0000_0004};
    tbl[2] = '{15'h7FFE, 4,  32'h0000_0008, 0, 32'h0000_0008};
    tbl[3] = '{15'h1234, 6,  32'h0000_003F, 6, 32'h0000_0001};
    tbl[4] = '{15'h0050, 0,  32'h0000_00FF, 0, 32'h0000_0000};
    tbl[5] = '{15'h0400, 40, 32'h8000_0001, 0, 32'h0000_0001};
    tbl[6] = '{15'h0000, 32, 32'hA5A5_0F0F, 0, 32'h0000_0001};
    tbl[7] = '{15'h0777, 1,  32'h0000_0001, 0, 32'h0000_0001};
`else
    tbl[0] = '{15'h0100, 4,  32'h0000_0000, 0, 32'h0000_0000};
    tbl[1] = '{15'h0010, 8,  32'h0000_0044, 0, 32'h0000_0044};
    tbl[2] = '{15'h7FFE, 4,  32'h0000_0008, 0, 32'h0000_0008};
    tbl[3] = '{15'h1234, 6,  32'h0000_003F, 6, 32'h0000_003F};
    tbl[4] = '{15'h0050, 0,  32'h0000_00FF, 0, 32'h0000_0000};
    tbl[5] = '{15'h0400, 40, 32'h8000_0001, 0, 32'h8000_0001};
    tbl[6] = '{15'h0000, 32, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F};
    tbl[7] = '{15'h0777, 1,  32'h0000_0001, 0, 32'h0000_0001};
`endif

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_req_ready", 32'(req_ready0), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rst_chk_vec", 32'(chk_vec0), 32'd0);
    check("rst_bitmap", rsp_bitmap0, 32'd0);
    check("rst_blocked", 32'(rsp_blocked0), 32'd0);
    check("rst_first", 32'(rsp_first0), 32'd0);
    check("rst_count", 32'(rsp_count0), 32'd0);
    check("rst_req_ready2", 32'(req_ready2), 32'd1);

    for (int i = 0; i < 8; i++) run0(tbl[i]);

    // CHK_LAT=2: each code held 3 cycles; mask is inverted on the non-sample cycles.
    p2        = 32'b101;
    req_base2 = 15'h0200;
    req_len2  = 6'd3;
    req_valid2 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      got = req_ready2;
      @(posedge CLK); #1;
    end
    req_valid2 = 1'b0;
    if (!got) bound_fail("accept2");
    else begin
      e = model(p2, 3, 2);
      sb.push_back(e);
      c = 0;
      while (!rsp_valid2 && c < 200) begin
        ix = c / 3;
        ev = 15'h0200 + 15'(ix);
        check("chk_vec2", 32'(chk_vec2), 32'(ev));
        chk_mask2 = (ix < 32) ? ((c % 3 == 2) ? p2[ix] : ~p2[ix]) : 1'b0;
        @(posedge CLK); #1;
        c++;
      end
      chk_mask2 = 1'b0;
      check("latency2", 32'(c + 1), 32'(e.lat));
      rsp_ready2 = 1'b1;
      cmp_rsp("rsp2", rsp_bitmap2, rsp_blocked2, rsp_first2, rsp_count2);
      @(posedge CLK); #1;
      rsp_ready2 = 1'b0;
      check("post_ready2", 32'(req_ready2), 32'd1);
    end

    // Reset in the middle of a len=20 scan, at idx 5.
    mbase0    = 15'h0300;
    mpat0     = 32'h0000_0400;
    req_base0 = 15'h0300;
    req_len0  = 6'd20;
    req_valid0 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      got = req_ready0;
      @(posedge CLK); #1;
    end
    req_valid0 = 1'b0;
    if (!got) bound_fail("accept_rst");
    repeat (5) begin
      @(posedge CLK); #1;
    end
    check("pre_rst_chk_vec", 32'(chk_vec0), 32'h0305);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("midrst_req_ready", 32'(req_ready0), 32'd1);
    check("midrst_chk_vec", 32'(chk_vec0), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("midrst_bitmap", rsp_bitmap0, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (rsp_valid0) seen = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    run0('{15'h0300, 20, 32'h0000_0400, 0, 32'h0000_0400});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
